dist_pipe_reg: RTL and testbench

DIST_PIPE_REG -- requirements
Module: dist_pipe_reg

---
 rtl/dist_pipe_reg.sv | 99 +++++++++
 tb/tb_dist_pipe_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dist_pipe_reg.sv
// Multi-stage valid/ready pipeline register with bubble collapsing and synchronous flush.
// Define DIST_PIPE_OCC_EN to build the registered occupancy counter; otherwise occupancy is 0.
module dist_pipe_reg #(
    parameter int unsigned WIDTH  = 260,
    parameter int unsigned STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int unsigned OccW = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ready, move;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic              in_xfer;

    // Readiness ripples from the output side back to stage 0.
    always_comb begin : handshake
        logic nxt_rdy;
        nxt_rdy = out_ready;
        move    = '0;
        ready   = '0;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            move[i]  = valid_q[i] & nxt_rdy;
            ready[i] = ~valid_q[i] | move[i];
            nxt_rdy  = ready[i];
        end
    end

    assign in_ready = ready[0] & ~flush;
    assign in_xfer  = in_valid & in_ready;

    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (move[i]) valid_d[i] = 1'b0;
        end
        if (in_xfer) begin
            valid_d[0] = 1'b1;
            data_d[0]  = in_data;
        end
        for (int i = 1; i < int'(STAGES); i++) begin
            if (move[i-1]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
            end
        end
        // Flush drops every entry but leaves payload registers untouched.
        if (flush) begin
            valid_d = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_data  = data_q[STAGES-1];
    assign out_valid = valid_q[STAGES-1];

`ifdef DIST_PIPE_OCC_EN
    logic [OccW-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OccW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) occ_q <= '0;
        else       occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`else
    assign occupancy = '0;
`endif

endmodule

// File: tb/tb_dist_pipe_reg.sv
// Directed bench for dist_pipe_reg: a STAGES=2 instance and a STAGES=3 instance.
// Occupancy expectations follow whether DIST_PIPE_OCC_EN is defined for the build.
module tb_dist_pipe_reg;

    localparam int unsigned W2 = 260;
    localparam int unsigned W3 = 16;
`ifdef DIST_PIPE_OCC_EN
    localparam bit OccOn = 1'b1;
`else
    localparam bit OccOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    logic [W2-1:0] a_in_data;
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [W2-1:0] a_out_data;
    logic [1:0]    a_occ;

    logic [W3-1:0] b_in_data;
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [W3-1:0] b_out_data;
    logic [1:0]    b_occ;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dist_pipe_reg #(.WIDTH(W2), .STAGES(2)) u_a (
        .clk       (clk),
        .reset     (reset),
        .in_data   (a_in_data),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .flush     (a_flush),
        .occupancy (a_occ)
    );

    dist_pipe_reg #(.WIDTH(W3), .STAGES(3)) u_b (
        .clk       (clk),
        .reset     (reset),
        .in_data   (b_in_data),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .flush     (b_flush),
        .occupancy (b_occ)
    );

    task automatic chk(input string tag, input logic [W2-1:0] obs, input logic [W2-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W2-1:0] occ_exp(input int n);
        return OccOn ? W2'(n) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        #2;
        chk("rst_a_out_valid", W2'(a_out_valid), '0);
        chk("rst_a_out_data", a_out_data, '0);
        chk("rst_a_in_ready", W2'(a_in_ready), W2'(1));
        chk("rst_a_occ", W2'(a_occ), '0);
        chk("rst_b_in_ready", W2'(b_in_ready), W2'(1));
        #6;
        reset = 1'b0;

        // Streaming: 1,2,3 back to back, out_ready high.
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = W2'(1);
        #1 chk("str_in_ready0", W2'(a_in_ready), W2'(1));
        tick();
        chk("str_c1_out_valid", W2'(a_out_valid), '0);
        chk("str_c1_in_ready", W2'(a_in_ready), W2'(1));
        a_in_data = W2'(2);
        tick();
        chk("str_c2_out", a_out_data, W2'(1));
        chk("str_c2_out_valid", W2'(a_out_valid), W2'(1));
        chk("str_c2_in_ready", W2'(a_in_ready), W2'(1));
        a_in_data = W2'(3);
        tick();
        chk("str_c3_out", a_out_data, W2'(2));
        chk("str_c3_in_ready", W2'(a_in_ready), W2'(1));
        a_in_valid = 1'b0;
        tick();
        chk("str_c4_out", a_out_data, W2'(3));
        chk("str_c4_out_valid", W2'(a_out_valid), W2'(1));
        tick();
        chk("str_c5_empty", W2'(a_out_valid), '0);
        chk("str_c5_occ", W2'(a_occ), occ_exp(0));

        // Backpressure: A,B,C with out_ready low.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = W2'('hA);
        tick();
        chk("bp_after_a_in_ready", W2'(a_in_ready), W2'(1));
        a_in_data = W2'('hB);
        tick();
        chk("bp_full_in_ready", W2'(a_in_ready), '0);
        chk("bp_full_out", a_out_data, W2'('hA));
        chk("bp_full_occ", W2'(a_occ), occ_exp(2));
        a_in_data = W2'('hC);
        tick();
        chk("bp_hold_in_ready", W2'(a_in_ready), '0);
        chk("bp_hold_out", a_out_data, W2'('hA));
        chk("bp_hold_valid", W2'(a_out_valid), W2'(1));
        a_out_ready = 1'b1;
        #1 chk("bp_drain_in_ready", W2'(a_in_ready), W2'(1));
        tick();
        a_in_valid = 1'b0;
        chk("bp_out_b", a_out_data, W2'('hB));
        chk("bp_occ_after_swap", W2'(a_occ), occ_exp(2));
        tick();
        chk("bp_out_c", a_out_data, W2'('hC));
        chk("bp_out_c_valid", W2'(a_out_valid), W2'(1));
        tick();
        chk("bp_empty", W2'(a_out_valid), '0);

        // Flush while full, with a competing input.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = W2'('h11);
        tick();
        a_in_data = W2'('h12);
        tick();
        chk("fl_full_out", a_out_data, W2'('h11));
        a_flush = 1'b1; a_in_data = W2'('h9);
        #1 chk("fl_in_ready", W2'(a_in_ready), '0);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        chk("fl_out_valid", W2'(a_out_valid), '0);
        chk("fl_occ", W2'(a_occ), '0);
        chk("fl_data_kept", a_out_data, W2'('h11));
        tick();
        chk("fl_no9_c1", W2'(a_out_valid), '0);
        tick();
        chk("fl_no9_c2", W2'(a_out_valid), '0);

        // Async reset between edges, then 0x7 after STAGES cycles.
        a_in_valid = 1'b1; a_in_data = W2'('h21);
        tick();
        a_in_data = W2'('h22);
        tick();
        a_in_valid = 1'b0;
        chk("ar_pre_out", a_out_data, W2'('h21));
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", W2'(a_out_valid), '0);
        chk("ar_out_data", a_out_data, '0);
        chk("ar_in_ready", W2'(a_in_ready), W2'(1));
        #1 reset = 1'b0;
        a_in_valid = 1'b1; a_in_data = W2'('h7);
        tick();
        a_in_valid = 1'b0;
        chk("ar_lat_c1", W2'(a_out_valid), '0);
        tick();
        chk("ar_lat_c2_valid", W2'(a_out_valid), W2'(1));
        chk("ar_lat_c2_data", a_out_data, W2'('h7));

        // Bubble collapse on the three-stage instance.
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = W3'('h5);
        tick();
        b_in_valid = 1'b0;
        tick();
        b_in_valid = 1'b1; b_in_data = W3'('h6);
        tick();
        b_in_valid = 1'b0;
        chk("bc_c3_out", W2'(b_out_data), W2'('h5));
        tick();
        tick();
        chk("bc_packed_valid", W2'(b_out_valid), W2'(1));
        chk("bc_packed_out", W2'(b_out_data), W2'('h5));
        chk("bc_packed_occ", W2'(b_occ), occ_exp(2));
        chk("bc_in_ready", W2'(b_in_ready), W2'(1));
        b_out_ready = 1'b1;
        tick();
        chk("bc_out_6", W2'(b_out_data), W2'('h6));
        chk("bc_occ_1", W2'(b_occ), occ_exp(1));
        tick();
        chk("bc_empty", W2'(b_out_valid), '0);
        chk("bc_occ_0", W2'(b_occ), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
